// File: rtl/obc_bitslice_accum.sv
// obc_bitslice_accum: bit-serial front/back end for the OBC distributed-arithmetic
// ROM stage of a 16-point DFT. Serialises 16 samples MSB-first onto the ROM
// address bits, shift-accumulates the returned ROM sum, adds the OBC offset
// and presents the result on a valid/ready handshake.
// Optional build macro: OBC_ROM_PIPE_EN -- ROM stage output is registered, so
// rom_in lags slice_out by one cycle; a one-cycle drain is added to SHIFT.
module obc_bitslice_accum #(
    parameter int DW = 16,
    parameter int RW = 32,
    parameter int AW = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [16*DW-1:0]  x_in,
    input  logic [RW-1:0]     offset,
    output logic [15:0]       slice_out,
    output logic              m_out,
    input  logic [RW-1:0]     rom_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AW-1:0]     y_out,
    output logic              busy
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state;
    logic [16*DW-1:0]   samp;
    logic [RW-1:0]      off_q;
    logic [AW-1:0]      acc;
    logic [CW-1:0]      cnt;
    logic [AW-1:0]      rom_x;
    logic [AW-1:0]      off_x;
    logic [AW-1:0]      acc_nxt;
`ifdef OBC_ROM_PIPE_EN
    logic               first;
    logic               drain;
`endif

    // Gather bit b of every sample into one 16-bit ROM address slice
    function automatic logic [15:0] slice_at(input logic [16*DW-1:0] v, input logic [CW-1:0] b);
        logic [15:0] s;
        s = '0;
        for (int k = 0; k < 16; k++) s[k] = v[k*DW + int'(b)];
        return s;
    endfunction

    // Sign extension of the ROM sum and offset, and the shift-accumulate step
    always_comb begin
        rom_x   = {{(AW-RW){rom_in[RW-1]}}, rom_in};
        off_x   = {{(AW-RW){off_q[RW-1]}}, off_q};
        acc_nxt = {acc[AW-2:0], 1'b0} + rom_x;
    end

    // Control FSM with registered outputs and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            y_out     <= '0;
            slice_out <= '0;
            m_out     <= 1'b0;
            busy      <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            samp      <= '0;
            off_q     <= '0;
`ifdef OBC_ROM_PIPE_EN
            first     <= 1'b0;
            drain     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        samp      <= x_in;
                        off_q     <= offset;
                        acc       <= '0;
                        cnt       <= CW'(DW-1);
                        // first slice (sign bits) is presented on the first SHIFT cycle
                        slice_out <= slice_at(x_in, CW'(DW-1));
                        m_out     <= 1'b1;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
`ifdef OBC_ROM_PIPE_EN
                        first     <= 1'b1;
                        drain     <= 1'b0;
`endif
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
`ifdef OBC_ROM_PIPE_EN
                    // rom_in on the first cycle belongs to no slice and is dropped
                    if (!first) acc <= acc_nxt;
                    first <= 1'b0;
                    if (drain) begin
                        y_out     <= acc_nxt + off_x;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (cnt == '0) begin
                        // last slice was driven; one more cycle to collect its ROM sum
                        drain     <= 1'b1;
                        slice_out <= '0;
                        m_out     <= 1'b0;
                    end else begin
                        cnt       <= cnt - 1'b1;
                        slice_out <= slice_at(samp, cnt - 1'b1);
                        m_out     <= 1'b0;
                    end
`else
                    acc <= acc_nxt;
                    if (cnt == '0) begin
                        y_out     <= acc_nxt + off_x;
                        out_valid <= 1'b1;
                        slice_out <= '0;
                        m_out     <= 1'b0;
                        state     <= DONE;
                    end else begin
                        cnt       <= cnt - 1'b1;
                        slice_out <= slice_at(samp, cnt - 1'b1);
                        m_out     <= 1'b0;
                    end
`endif
                end
                DONE: begin
                    // new input only becomes acceptable the cycle after the output handshake
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_obc_bitslice_accum.sv
// Directed self-checking bench for obc_bitslice_accum with a small ROM-stage model.
module tb_obc_bitslice_accum;
    localparam int DW = 16;
    localparam int RW = 32;
    localparam int AW = 48;
`ifdef OBC_ROM_PIPE_EN
    localparam int LAT = DW + 2;
`else
    localparam int LAT = DW + 1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [16*DW-1:0]  x_in;
    logic [RW-1:0]     offset;
    logic [15:0]       slice_out;
    logic              m_out;
    logic [RW-1:0]     rom_in;
    logic              out_valid;
    logic              out_ready;
    logic [AW-1:0]     y_out;
    logic              busy;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // ROM-stage model: either a constant sum or 1 only on the sign slice
    logic [RW-1:0] rom_const;
    bit            rom_mode;
    logic [RW-1:0] rom_fn;
    assign rom_fn = rom_mode ? {{(RW-1){1'b0}}, m_out} : rom_const;
`ifdef OBC_ROM_PIPE_EN
    logic [RW-1:0] rom_q = '0;
    always @(posedge clk) rom_q <= rom_fn;
    assign rom_in = rom_q;
`else
    assign rom_in = rom_fn;
`endif

    always #5 clk = ~clk;

    obc_bitslice_accum #(.DW(DW), .RW(RW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .offset(offset), .slice_out(slice_out), .m_out(m_out),
        .rom_in(rom_in), .out_valid(out_valid), .out_ready(out_ready),
        .y_out(y_out), .busy(busy)
    );

    logic [15:0]   sl_rec [0:40];
    logic          m_rec  [0:40];
    logic [AW-1:0] y_got;
    int            lat;

    // Present one sample set, record slices per SHIFT cycle and find out_valid
    task automatic run_set(input logic [16*DW-1:0] x, input logic [RW-1:0] off);
        @(negedge clk);
        x_in = x; offset = off; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        x_in = '1; offset = 32'h1234_5678;   // may change freely while busy
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            sl_rec[c] = slice_out; m_rec[c] = m_out;
            if (out_valid) begin lat = c; break; end
            @(negedge clk);
        end
        y_got = y_out;
    endtask

    task automatic take_output();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x_in = '0; offset = '0;
        rom_const = 32'd1; rom_mode = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (5) @(negedge clk);
        chk_cnt++; if ({in_ready, out_valid, busy, m_out} !== 4'b1000) $display("FAIL reset_ctl got %b exp 1000", {in_ready, out_valid, busy, m_out}); else pass_cnt++;
        chk_cnt++; if (y_out !== '0) $display("FAIL reset_y got %0h exp 0", y_out); else pass_cnt++;
        chk_cnt++; if (slice_out !== 16'h0) $display("FAIL reset_slice got %0h exp 0", slice_out); else pass_cnt++;
    endtask

    task automatic test_slices_const_one();
        logic [15:0] es;
        logic        em;
        int          nbad;
        rom_mode = 1'b0; rom_const = 32'd1;
        run_set(256'h8001, 32'd0);
        nbad = 0;
        for (int c = 1; c < LAT; c++) begin
            es = (c == 1 || c == 16) ? 16'h0001 : 16'h0000;
            em = (c == 1);
            chk_cnt++;
            if (sl_rec[c] !== es || m_rec[c] !== em) begin
                $display("FAIL slice_c%0d got %0h/%b exp %0h/%b", c, sl_rec[c], m_rec[c], es, em);
                nbad++;
            end else pass_cnt++;
        end
        chk_cnt++; if (lat !== LAT) $display("FAIL latency_one got %0d exp %0d", lat, LAT); else pass_cnt++;
        chk_cnt++; if (y_got !== 48'd65535) $display("FAIL y_const_one got %0h exp %0h", y_got, 48'd65535); else pass_cnt++;
        take_output();
        chk_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL release got %b%b exp 01", out_valid, in_ready); else pass_cnt++;
    endtask

    task automatic test_negative();
        rom_mode = 1'b0; rom_const = 32'hFFFF_FFFF;
        run_set(256'h8001, 32'd5);
        chk_cnt++; if (y_got !== 48'hFFFF_FFFF_0006) $display("FAIL y_neg got %0h exp ffffffff0006", y_got); else pass_cnt++;
        take_output();
        rom_mode = 1'b1;
        run_set(256'h8001, 32'd0);
        chk_cnt++; if (y_got !== 48'd32768) $display("FAIL y_sign_only got %0h exp 8000", y_got); else pass_cnt++;
        chk_cnt++; if (lat !== LAT) $display("FAIL latency_sign got %0d exp %0d", lat, LAT); else pass_cnt++;
        take_output();
        rom_mode = 1'b0;
    endtask

    task automatic test_back_to_back();
        int c2;
        rom_const = 32'd1;
        @(negedge clk);
        x_in = 256'h8001; offset = 32'd0; in_valid = 1'b1;
        lat = 0;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (out_valid) begin lat = c + 1; break; end
        end
        chk_cnt++; if (lat !== LAT) $display("FAIL bp_latency got %0d exp %0d", lat, LAT); else pass_cnt++;
        y_got = y_out;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_cnt++;
            if (out_valid !== 1'b1 || y_out !== y_got || in_ready !== 1'b0)
                $display("FAIL bp_hold%0d got %b/%0h/%b exp 1/%0h/0", i, out_valid, y_out, in_ready, y_got);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk_cnt++; if ({out_valid, in_ready, busy} !== 3'b010) $display("FAIL bp_idle got %b exp 010", {out_valid, in_ready, busy}); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if ({busy, in_ready, m_out} !== 3'b101) $display("FAIL bp_accept got %b exp 101", {busy, in_ready, m_out}); else pass_cnt++;
        in_valid = 1'b0;
        c2 = 0;
        for (int c = 1; c <= 40; c++) begin
            if (out_valid) begin c2 = c; break; end
            @(negedge clk);
        end
        chk_cnt++; if (c2 !== LAT) $display("FAIL b2b_latency got %0d exp %0d", c2, LAT); else pass_cnt++;
        chk_cnt++; if (y_out !== 48'd65535) $display("FAIL b2b_y got %0h exp ffff", y_out); else pass_cnt++;
        take_output();
    endtask

    task automatic test_mid_reset();
        rom_const = 32'd1;
        @(negedge clk);
        x_in = 256'h8001; offset = 32'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);          // now at SHIFT cycle 7
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_cnt++; if ({in_ready, out_valid, busy, m_out} !== 4'b1000) $display("FAIL midrst_ctl got %b exp 1000", {in_ready, out_valid, busy, m_out}); else pass_cnt++;
        chk_cnt++; if (y_out !== '0 || slice_out !== 16'h0) $display("FAIL midrst_data got %0h/%0h exp 0/0", y_out, slice_out); else pass_cnt++;
        run_set(256'h8001, 32'd0);
        chk_cnt++; if (lat !== LAT) $display("FAIL restart_latency got %0d exp %0d", lat, LAT); else pass_cnt++;
        chk_cnt++; if (y_got !== 48'd65535) $display("FAIL restart_y got %0h exp ffff", y_got); else pass_cnt++;
        take_output();
    endtask

    initial begin
        test_reset();
        test_slices_const_one();
        test_negative();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
